// File: rtl/eth_udp_rx_wide.sv
// GMII Ethernet/IPv4/UDP receiver that packs the UDP payload into OUT_BYTES-wide words, first byte in the MSBs.
// Optional UDP_PORT_FILTER_EN: when defined, frames whose UDP dest port differs from BOARD_PORT are dropped silently.
module eth_udp_rx_wide #(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [15:0] BOARD_PORT = 16'd1234,
  parameter int          OUT_BYTES  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gmii_rx_dv,
  input  logic [7:0]             gmii_rxd,
  output logic                   rec_en,
  output logic [8*OUT_BYTES-1:0] rec_data,
  output logic [OUT_BYTES-1:0]   rec_keep,
  output logic                   rec_pkt_done,
  output logic                   rec_err,
  output logic [15:0]            rec_byte_num,
  output logic [31:0]            rec_src_ip,
  output logic [15:0]            rec_src_port
);
  localparam int         W         = 8*OUT_BYTES;
  localparam logic [2:0] LAST_SLOT = 3'(OUT_BYTES-1);
`ifdef UDP_PORT_FILTER_EN
  localparam bit PORT_FILTER = 1'b1;
`else
  localparam bit PORT_FILTER = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_END} state_t;

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [47:0]          dmac_q, dmac_d;
  logic [7:0]           prev_q, prev_d;
  logic [3:0]           ihl_q, ihl_d;
  logic [31:0]          sip_q, sip_d;
  logic [23:0]          dip_q, dip_d;
  logic [15:0]          sport_q, sport_d;
  logic [15:0]          nbytes_q, nbytes_d;
  logic [2:0]           slot_q, slot_d;
  logic [W-1:0]         acc_q, acc_d;
  logic [OUT_BYTES-1:0] acck_q, acck_d;
  logic                 rec_en_q, rec_en_d;
  logic                 rec_done_q, rec_done_d;
  logic                 rec_err_q, rec_err_d;
  logic [W-1:0]         rec_data_q, rec_data_d;
  logic [OUT_BYTES-1:0] rec_keep_q, rec_keep_d;
  logic [15:0]          rec_num_q, rec_num_d;
  logic [31:0]          rec_ip_q, rec_ip_d;
  logic [15:0]          rec_port_q, rec_port_d;

  logic [W-1:0]         acc_byte;
  logic [OUT_BYTES-1:0] keep_byte;
  logic                 last_byte;

  assign last_byte = (cnt_q == nbytes_q - 16'd1);

  // Current word with the incoming byte merged into its slot; slot 0 starts a fresh, zero-filled word.
  always_comb begin
    acc_byte  = (slot_q == 3'd0) ? '0 : acc_q;
    keep_byte = (slot_q == 3'd0) ? '0 : acck_q;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (slot_q == 3'(i)) begin
        acc_byte[W-8-8*i +: 8]   = gmii_rxd;
        keep_byte[OUT_BYTES-1-i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dmac_d     = dmac_q;
    prev_d     = gmii_rxd;
    ihl_d      = ihl_q;
    sip_d      = sip_q;
    dip_d      = dip_q;
    sport_d    = sport_q;
    nbytes_d   = nbytes_q;
    slot_d     = slot_q;
    acc_d      = acc_q;
    acck_d     = acck_q;
    rec_en_d   = 1'b0;
    rec_done_d = 1'b0;
    rec_err_d  = 1'b0;
    rec_data_d = rec_data_q;
    rec_keep_d = rec_keep_q;
    rec_num_d  = rec_num_q;
    rec_ip_d   = rec_ip_q;
    rec_port_d = rec_port_q;

    case (state_q)
      IDLE: begin
        slot_d = 3'd0;
        if (gmii_rx_dv) state_d = (gmii_rxd == 8'h55) ? PREAMBLE : RX_END;
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) state_d = IDLE;
        else if (gmii_rxd == 8'h55 && cnt_q < 16'd6) cnt_d = cnt_q + 16'd1;
        else if (gmii_rxd == 8'hD5 && cnt_q == 16'd6) state_d = ETH_HEAD;
        else state_d = RX_END;
      end
      ETH_HEAD: begin
        if (!gmii_rx_dv) begin
          rec_err_d = 1'b1;
          state_d   = RX_END;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q < 16'd6) dmac_d = {dmac_q[39:0], gmii_rxd};
          if (cnt_q == 16'd13) begin
            if ((dmac_q == BOARD_MAC || dmac_q == '1) && {prev_q, gmii_rxd} == 16'h0800)
              state_d = IP_HEAD;
            else
              state_d = RX_END;
          end
        end
      end
      IP_HEAD: begin
        if (!gmii_rx_dv) begin
          rec_err_d = 1'b1;
          state_d   = RX_END;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd0) ihl_d = gmii_rxd[3:0];
          if (cnt_q >= 16'd12 && cnt_q <= 16'd15) sip_d = {sip_q[23:0], gmii_rxd};
          if (cnt_q >= 16'd16 && cnt_q <= 16'd18) dip_d = {dip_q[15:0], gmii_rxd};
          if (cnt_q == 16'd0 && gmii_rxd[3:0] < 4'd5)
            state_d = RX_END;
          else if (cnt_q == 16'd9 && gmii_rxd != 8'd17)
            state_d = RX_END;
          else if (cnt_q == 16'd19 && {dip_q, gmii_rxd} != BOARD_IP)
            state_d = RX_END;
          else if (cnt_q >= 16'd19 && cnt_q == {10'd0, ihl_q, 2'b00} - 16'd1)
            state_d = UDP_HEAD;
        end
      end
      UDP_HEAD: begin
        if (!gmii_rx_dv) begin
          rec_err_d = 1'b1;
          state_d   = RX_END;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd1) sport_d = {prev_q, gmii_rxd};
          if (cnt_q == 16'd3 && PORT_FILTER && {prev_q, gmii_rxd} != BOARD_PORT) state_d = RX_END;
          if (cnt_q == 16'd5) nbytes_d = {prev_q, gmii_rxd};
          if (cnt_q == 16'd7) begin
            if (nbytes_q < 16'd8) begin
              state_d = RX_END;
            end else if (nbytes_q == 16'd8) begin
              // Empty datagram: report completion without any data word.
              rec_done_d = 1'b1;
              rec_num_d  = 16'd0;
              rec_ip_d   = sip_q;
              rec_port_d = sport_q;
              state_d    = RX_END;
            end else begin
              nbytes_d = nbytes_q - 16'd8;
              state_d  = RX_DATA;
            end
          end
        end
      end
      RX_DATA: begin
        if (!gmii_rx_dv) begin
          rec_err_d = 1'b1;
          state_d   = RX_END;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (slot_q == LAST_SLOT || last_byte) begin
            rec_en_d   = 1'b1;
            rec_data_d = acc_byte;
            rec_keep_d = keep_byte;
            slot_d     = 3'd0;
          end else begin
            acc_d  = acc_byte;
            acck_d = keep_byte;
            slot_d = slot_q + 3'd1;
          end
          if (last_byte) begin
            rec_done_d = 1'b1;
            rec_num_d  = nbytes_q;
            rec_ip_d   = sip_q;
            rec_port_d = sport_q;
            state_d    = RX_END;
          end
        end
      end
      RX_END: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d  = '0;
      slot_d = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dmac_q     <= '0;
      prev_q     <= '0;
      ihl_q      <= '0;
      sip_q      <= '0;
      dip_q      <= '0;
      sport_q    <= '0;
      nbytes_q   <= '0;
      slot_q     <= '0;
      acc_q      <= '0;
      acck_q     <= '0;
      rec_en_q   <= 1'b0;
      rec_done_q <= 1'b0;
      rec_err_q  <= 1'b0;
      rec_data_q <= '0;
      rec_keep_q <= '0;
      rec_num_q  <= '0;
      rec_ip_q   <= '0;
      rec_port_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dmac_q     <= dmac_d;
      prev_q     <= prev_d;
      ihl_q      <= ihl_d;
      sip_q      <= sip_d;
      dip_q      <= dip_d;
      sport_q    <= sport_d;
      nbytes_q   <= nbytes_d;
      slot_q     <= slot_d;
      acc_q      <= acc_d;
      acck_q     <= acck_d;
      rec_en_q   <= rec_en_d;
      rec_done_q <= rec_done_d;
      rec_err_q  <= rec_err_d;
      rec_data_q <= rec_data_d;
      rec_keep_q <= rec_keep_d;
      rec_num_q  <= rec_num_d;
      rec_ip_q   <= rec_ip_d;
      rec_port_q <= rec_port_d;
    end
  end

  assign rec_en       = rec_en_q;
  assign rec_data     = rec_data_q;
  assign rec_keep     = rec_keep_q;
  assign rec_pkt_done = rec_done_q;
  assign rec_err      = rec_err_q;
  assign rec_byte_num = rec_num_q;
  assign rec_src_ip   = rec_ip_q;
  assign rec_src_port = rec_port_q;
endmodule
